// File: rtl/io_responder.sv
// CPU data-bus I/O page responder: digits, timer, LEDs, debounced switches, 7-seg scan.
// Reads are combinational (0 cycles), writes land at the edge; the bus has no backpressure.
module io_responder #(
  parameter int SCAN_DIV = 20000,
  parameter int DEBOUNCE = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wr,
  output logic [31:0] rd,
  output logic        hit,
  input  logic [23:0] device_sw,
  output logic [23:0] device_led,
  output logic [7:0]  led_en,
  output logic [7:0]  seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [9:0] OFF_DIGITS = 10'h000;
  localparam logic [9:0] OFF_TIMER  = 10'h008;
  localparam logic [9:0] OFF_LED    = 10'h018;
  localparam logic [9:0] OFF_SW     = 10'h01C;

  logic [31:0]   r_digits;
  logic [31:0]   r_timer;
  logic [23:0]   r_led;
  logic [23:0]   r_sw_meta;
  logic [23:0]   r_sw_sync;
  logic [23:0]   r_cand;
  logic [23:0]   r_sw;
  logic [DW-1:0] r_dcnt;
  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_idx;

  logic [9:0]    w_off;
  logic          w_hit;
  logic          w_wr_digits;
  logic          w_wr_timer;
  logic          w_wr_led;
  logic [PW-1:0] w_pcnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [3:0]    w_nib;
  logic          w_unused;

  // Byte lanes are not supported; every access is a full word.
  assign w_unused = ^addr[1:0];

  assign w_off       = addr[11:2];
  assign w_hit       = (addr[31:12] == 20'hFFFFF);
  assign w_wr_digits = we && w_hit && (w_off == OFF_DIGITS);
  assign w_wr_timer  = we && w_hit && (w_off == OFF_TIMER);
  assign w_wr_led    = we && w_hit && (w_off == OFF_LED);

  assign hit        = w_hit;
  assign device_led = r_led;

  always_comb begin
    rd = 32'h0;
    if (w_hit) begin
      case (w_off)
        OFF_DIGITS: rd = r_digits;
        OFF_TIMER:  rd = r_timer;
        OFF_LED:    rd = {8'h0, r_led};
        OFF_SW:     rd = {8'h0, r_sw};
        default:    rd = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_timer  <= '0;
      r_led    <= '0;
    end else begin
      if (w_wr_digits) r_digits <= wr;
      if (w_wr_led)    r_led    <= wr[23:0];
      r_timer <= w_wr_timer ? wr : r_timer + 32'd1;
    end
  end

  // Whole-vector debounce: any bit moving restarts the stability count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_cand    <= '0;
      r_dcnt    <= '0;
      r_sw      <= '0;
    end else begin
      r_sw_meta <= device_sw;
      r_sw_sync <= r_sw_meta;
      if (r_sw_sync != r_cand) begin
        r_cand <= r_sw_sync;
        r_dcnt <= '0;
      end else if (r_dcnt != DW'(DEBOUNCE - 1)) begin
        r_dcnt <= r_dcnt + DW'(1);
      end else begin
        r_sw <= r_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      r_idx  <= w_idx_nxt;
    end
  end

  always_comb begin
    w_pcnt_nxt = r_pcnt + PW'(1);
    w_idx_nxt  = r_idx;
    if (r_pcnt == PW'(SCAN_DIV - 1)) begin
      w_pcnt_nxt = '0;
      w_idx_nxt  = r_idx + 3'd1;
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Segments follow the live DIGITS register, so a write shows up mid-slot.
  always_comb begin
    w_nib  = r_digits[{r_idx, 2'b00} +: 4];
    led_en = ~(8'b1 << r_idx);
    seg    = hex7(w_nib);
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: vector table, hand-written corner sequences, randomized run vs a reference model.
module tb_io_responder;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wr;
  logic [31:0] rd;
  logic        hit;
  logic [23:0] device_sw;
  logic [23:0] device_led;
  logic [7:0]  led_en;
  logic [7:0]  seg;

  io_responder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wr(wr), .rd(rd), .hit(hit),
    .device_sw(device_sw), .device_led(device_led), .led_en(led_en), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] hexseg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state, advanced once per rising edge from the bench's own inputs.
  logic [31:0] m_digits, m_timer;
  logic [23:0] m_led, m_sw;
  int          m_cyc;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wr;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a[31:12] != 20'hFFFFF) return 32'h0;
    case ({a[11:2], 2'b00})
      12'h000: return m_digits;
      12'h020: return m_timer;
      12'h060: return {8'h0, m_led};
      12'h070: return {8'h0, m_sw};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_digits = 0; m_timer = 0; m_led = 0; m_sw = 0; m_cyc = 0;
    end else begin
      m_timer = m_timer + 32'd1;
      if (we && addr[31:12] == 20'hFFFFF) begin
        case ({addr[11:2], 2'b00})
          12'h000: m_digits = wr;
          12'h020: m_timer  = wr;
          12'h060: m_led    = wr[23:0];
          default: ;
        endcase
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_scan(input string name);
    int i;
    logic [7:0] en_exp;
    i = (m_cyc / SD) % 8;
    en_exp = ~(8'b1 << i);
    chk({name, "_led_en"}, {24'h0, led_en}, {24'h0, en_exp});
    chk({name, "_seg"}, {24'h0, seg}, {24'h0, hexseg[m_digits[4*i +: 4]]});
  endtask

  initial begin
    addr = 32'h0; we = 1'b0; wr = 32'h0; device_sw = 24'h0; rst_n = 1'b0;
    #1;

    // Reset
    do_reset();
    addr = 32'hFFFFF020;
    @(negedge clk);
    chk("rst_led", {8'h0, device_led}, 32'h0);
    chk("rst_led_en", {24'h0, led_en}, 32'hFE);
    chk("rst_seg", {24'h0, seg}, 32'hC0);
    chk("rst_timer", rd, 32'h0);
    tick();

    // Decode / LED vector table
    vecs[0]  = '{32'hFFFFF060, 1'b1, 32'h00ABCDEF, 32'h0,        1'b1, 24'h0};
    vecs[1]  = '{32'hFFFFF060, 1'b0, 32'h0,        32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[2]  = '{32'hFFFFF064, 1'b1, 32'h00123456, 32'h0,        1'b1, 24'hABCDEF};
    vecs[3]  = '{32'hFFFFF060, 1'b0, 32'h0,        32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[4]  = '{32'h7FFFF060, 1'b1, 32'h00111111, 32'h0,        1'b0, 24'hABCDEF};
    vecs[5]  = '{32'hFFFFF060, 1'b0, 32'h0,        32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[6]  = '{32'hFFFFF010, 1'b0, 32'h0,        32'h0,        1'b1, 24'hABCDEF};
    vecs[7]  = '{32'h00000010, 1'b0, 32'h0,        32'h0,        1'b0, 24'hABCDEF};
    vecs[8]  = '{32'hFFFFF070, 1'b1, 32'h00FFFFFF, 32'h0,        1'b1, 24'hABCDEF};
    vecs[9]  = '{32'hFFFFF070, 1'b0, 32'h0,        32'h0,        1'b1, 24'hABCDEF};
    vecs[10] = '{32'hFFFFF063, 1'b1, 32'hFF123456, 32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[11] = '{32'hFFFFF060, 1'b0, 32'h0,        32'h00123456, 1'b1, 24'h123456};
    for (int v = 0; v < 12; v++) begin
      addr = vecs[v].addr; we = vecs[v].we; wr = vecs[v].wr;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d_hit", v), {31'h0, hit}, {31'h0, vecs[v].exp_hit});
      chk($sformatf("vec%0d_led", v), {8'h0, device_led}, {8'h0, vecs[v].exp_led});
      tick();
    end
    we = 1'b0;

    // Timer wrap and write priority
    addr = 32'hFFFFF020; we = 1'b1; wr = 32'hFFFFFFFE;
    tick();
    we = 1'b0;
    @(negedge clk); chk("tmr_fffffffe", rd, 32'hFFFFFFFE); tick();
    @(negedge clk); chk("tmr_ffffffff", rd, 32'hFFFFFFFF); tick();
    @(negedge clk); chk("tmr_wrap0", rd, 32'h0);
    we = 1'b1; wr = 32'd5; tick();
    wr = 32'd9; tick();
    we = 1'b0;
    @(negedge clk); chk("tmr_b2b_9", rd, 32'd9); tick();
    @(negedge clk); chk("tmr_b2b_10", rd, 32'd10); tick();

    // Scan: digit i holds value i
    do_reset();
    addr = 32'hFFFFF000; we = 1'b1; wr = 32'h76543210;
    tick();
    we = 1'b0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      chk_scan($sformatf("scan%0d", k));
      if (k == 0) chk("scan_digits_rd", rd, 32'h76543210);
      tick();
    end

    // Debounce: short glitch must be rejected
    addr = 32'hFFFFF070;
    device_sw = 24'h000001;
    repeat (5) tick();
    device_sw = 24'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("glitch%0d", k), rd, 32'h0);
      tick();
    end
    // Clean step accepted exactly 2 + 1 + DB edges later
    device_sw = 24'h000001;
    for (int k = 1; k <= 13; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("deb_edge%0d", k), rd, (k >= 2 + 1 + DB) ? 32'h1 : 32'h0);
    end

    // Randomized traffic against the model
    device_sw = 24'($urandom);
    repeat (2 + 1 + DB + 2) tick();
    m_sw = device_sw;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: addr = 32'hFFFFF000;
        1: addr = 32'hFFFFF020;
        2: addr = 32'hFFFFF060;
        3: addr = 32'hFFFFF070;
        4: addr = {20'hFFFFF, 12'($urandom)};
        5: addr = {20'hFFFFF, 7'h0, 5'($urandom)};
        6: addr = {20'($urandom) & 20'h7FFFF, 12'h060};
        default: addr = {20'hFFFFF, 10'($urandom_range(0, 31)), 2'($urandom)};
      endcase
      we = ($urandom_range(0, 2) == 0);
      wr = $urandom;
      @(negedge clk);
      chk("rnd_hit", {31'h0, hit}, {31'h0, addr[31:12] == 20'hFFFFF});
      chk("rnd_rd", rd, mread(addr));
      chk("rnd_led", {8'h0, device_led}, {8'h0, m_led});
      chk_scan("rnd");
      tick();
    end

    // Reset coincident with a store: reset wins
    rst_n = 1'b0; addr = 32'hFFFFF060; we = 1'b1; wr = 32'h00FFFFFF;
    tick();
    rst_n = 1'b1; we = 1'b0; addr = 32'hFFFFF020;
    @(negedge clk);
    chk("rstwe_led", {8'h0, device_led}, 32'h0);
    chk("rstwe_led_en", {24'h0, led_en}, 32'hFE);
    chk("rstwe_timer", rd, 32'h0);
    tick();
    @(negedge clk);
    chk("rstwe_timer1", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped peripheral responder on the CPU data bus. It decodes CPU load/store accesses to the I/O page 0xFFFFF000–0xFFFFFFFF and answers them from its own registers. It drives the 24 board LEDs, debounces and exposes the 24 switches, scans an 8-digit seven-segment display, and provides a free-running cycle timer. It sits beside the data RAM; the RAM-side read mux selects `rd` whenever `hit` is 1.

## Interface
- `SCAN_DIV`, default 20000: clock cycles per seven-segment digit slot.
- `DEBOUNCE`, default 10000: consecutive stable cycles required before a switch change is accepted.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `addr` input 32: byte address from the CPU ALU result.
- `we` input 1: store strobe, valid in the same cycle as `addr`.
- `wr` input 32: store data.
- `rd` output 32: load data, combinational.
- `hit` output 1: combinational; 1 when `addr[31:12] == 20'hFFFFF`.
- `device_sw` input 24: raw asynchronous switch inputs.
- `device_led` output 24: LED register.
- `led_en` output 8: digit enables, active-low one-hot.
- `seg` output 8: segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- **Address map.** Decode uses word offset `addr[11:0]`; `addr[1:0]` is ignored. All accesses are full-word.
  - 0x000 DIGITS: read/write, 32 bits; nibble i is shown on digit i.
  - 0x020 TIMER: read/write, 32 bits.
  - 0x060 LED: read/write; uses `wr[23:0]`. Reads return {8'h0, led}.
  - 0x070 SW: read-only; returns {8'h0, debounced switches}. Writes are ignored.
  - Any other offset inside the page: reads return 0, writes are ignored.
  - `hit` = 0: `rd` = 0 and no register changes.
- **Writes.** A register updates at the rising edge where `we` = 1 and `hit` = 1 and the offset matches.
- **Timer.**
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A write loads `wr`. If a write and an increment coincide, the write wins; the counter holds `wr` after that edge and increments from it on the next edge.
- **Switches.**
  - Two-flop synchronizer feeds the debouncer (`sync`).
  - Debounce counter `dcnt` resets to 0 whenever `sync` ≠ `cand`, and at the same edge `cand` ← `sync`.
  - Otherwise `dcnt` increments, saturating at `DEBOUNCE`-1.
  - When `dcnt` == `DEBOUNCE`-1 and `sync` == `cand`, the stable register ← `cand`.
  - The debouncer operates on the whole 24-bit vector together: any bit change restarts the count.
- **Scan state machine.**
  - Prescaler `pcnt` counts 0..`SCAN_DIV`-1.
  - When `pcnt` = `SCAN_DIV`-1, `pcnt` ← 0 and digit index `idx` ← `idx`+1 (3-bit, 7 wraps to 0).
  - `led_en` = ~(8'b1 << `idx`).
  - `seg` = hexdecode(DIGITS[4·idx+3 : 4·idx]) with dp always 1 (off).
- **Hex decode** (8-bit values, dp included): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.

## Timing
- **Reset values** (`rst_n` low at an edge):
  - DIGITS=0, TIMER=0, LED=0, stable switches=0, synchronizer flops=0, `cand`=0, `dcnt`=0, `pcnt`=0, `idx`=0.
  - Hence `device_led`=0, `led_en`=8'hFE, `seg`=8'hC0.
- Reset mid-scan or mid-debounce abandons the count immediately; there is no partial state.
- Reset asserted coincident with `we` = 1: reset wins.
- **Read latency** is 0 cycles (combinational from registers), matching the single-cycle CPU's load path.
- **Write latency:** a value written at edge N appears on `rd`/`device_led` after edge N.
- **Switch latency:** a clean step on `device_sw` reaches SW after 2 (sync) + 1 (`cand`) + `DEBOUNCE` cycles.
- **Digit dwell:** each digit is shown for exactly `SCAN_DIV` cycles; a full frame is 8·`SCAN_DIV`.
- A DIGITS write takes effect on `seg` right after its edge, without waiting for the next slot.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release. Expect `device_led`=0, `led_en`=FE, `seg`=C0, and reads of TIMER at cycle 0 after release = 0.
- **LED and decode.**
  - Store 0x00ABCDEF to 0xFFFFF060. Expect `device_led`=ABCDEF next cycle and a readback of 0x00ABCDEF.
  - Store to 0xFFFFF064: no effect. Store to 0xFFFFF000 with `hit`=0 address 0x7FFFF060: no LED change.
- **Scan.** With `SCAN_DIV`=4, write DIGITS=0x76543210.
  - Expect `led_en` stepping FE, FD, FB, … 7F every 4 cycles.
  - `seg` sequence C0, F9, A4, B0, 99, 92, 82, F8, then wrap to FE/C0.
- **Debounce.** With `DEBOUNCE`=8, drive `device_sw`=0x000001.
  - Glitch: 5 cycles high then 0. SW read stays 0.
  - Hold high: SW = 0x000001 exactly 11 cycles after the step.
- **Timer.**
  - Write 0xFFFFFFFE. Expect reads of FFFFFFFE, FFFFFFFF, 00000000 on consecutive cycles.
  - Back-to-back writes of 5 then 9: the read after the second write = 9.
- **Unmapped.** Reading 0xFFFFF010 returns 0 with `hit`=1. Reading 0x00000010 returns `rd`=0 with `hit`=0.
